// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HOLD,
        RUN,
        MEM_WAIT
    } hz_state_t;

    // True when a writing stage targets a non-zero register equal to rs.
    function automatic logic reg_match(input logic we, input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] rs);
        return we && (rd != REG_ZERO) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_sel_unit.sv
// Forwarding source select for one EX operand; MEM result beats WB result.
module fwd_sel_unit
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output fwd_sel_t         sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_match(mem_reg_write, mem_rd, rs)) begin
            sel = FWD_MEM;
        end else if (reg_match(wb_reg_write, wb_rd, rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush/forwarding controller with reset hold, memory wait
// sequencing and stall/flush performance counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned RESET_HOLD  = 2,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clear,
    output logic             idex_en,
    output logic             idex_clear,
    output logic             exmem_en,
    output logic             exmem_clear,
    output logic             memwb_en,
    output logic             memwb_clear,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    localparam int unsigned HOLD_W = $clog2(RESET_HOLD) + 1;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t          state;
    hz_state_t          state_nxt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_nxt;
    logic               mem_stall;
    logic               redirect_act;
    logic               load_use;
    fwd_sel_t           fwd_a_sel;
    fwd_sel_t           fwd_b_sel;

    fwd_sel_unit u_fwd_a (
        .rs            (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_a_sel)
    );

    fwd_sel_unit u_fwd_b (
        .rs            (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .sel           (fwd_b_sel)
    );

    assign fwd_a = fwd_a_sel;
    assign fwd_b = fwd_b_sel;

    assign load_use = ex_is_load && (ex_rd != REG_ZERO)
                   && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Next state and stage controls; wait > redirect > load-use.
    always_comb begin
        state_nxt    = state;
        mem_stall    = 1'b0;
        redirect_act = 1'b0;
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_clear   = 1'b0;
        idex_en      = 1'b1;
        idex_clear   = 1'b0;
        exmem_en     = 1'b1;
        exmem_clear  = 1'b0;
        memwb_en     = 1'b1;
        memwb_clear  = 1'b0;
        case (state)
            HOLD: begin
                pc_en       = 1'b0;
                ifid_clear  = 1'b1;
                idex_clear  = 1'b1;
                exmem_clear = 1'b1;
                memwb_clear = 1'b1;
                if (hold_cnt == HOLD_W'(RESET_HOLD - 1)) begin
                    state_nxt = RUN;
                end
            end
            RUN, MEM_WAIT: begin
                if (mem_req && !mem_ready) begin
                    mem_stall   = 1'b1;
                    state_nxt   = MEM_WAIT;
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_en     = 1'b0;
                    exmem_en    = 1'b0;
                    memwb_clear = 1'b1;
                end else begin
                    state_nxt = RUN;
                    if (ex_redirect) begin
                        redirect_act = 1'b1;
                        ifid_clear   = 1'b1;
                        idex_clear   = 1'b1;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_clear = 1'b1;
                    end
                end
            end
            default: state_nxt = HOLD;
        endcase
    end

    // Wait counter restarts at 1 on the first wait cycle and saturates.
    always_comb begin
        wait_nxt = wait_cnt;
        if (mem_stall) begin
            if (state != MEM_WAIT) begin
                wait_nxt = WAIT_W'(1);
            end else if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                wait_nxt = wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= HOLD;
            hold_cnt    <= '0;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (state == HOLD) begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
            if ((state != HOLD) && !pc_en) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (redirect_act) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (mem_stall && (wait_nxt == WAIT_W'(MEM_TIMEOUT))) begin
                mem_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        ex_is_load, ex_redirect, mem_reg_write, wb_reg_write;
    logic        mem_req, mem_ready;
    logic        pc_en, ifid_en, ifid_clear, idex_en, idex_clear;
    logic        exmem_en, exmem_clear, memwb_en, memwb_clear;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;
    logic        mem_timeout;
    logic [8:0]  ctrl;

    int n_checks = 0;
    int n_fails  = 0;

    // {pc, ifid en/clr, idex en/clr, exmem en/clr, memwb en/clr}
    localparam logic [8:0] C_HOLD  = 9'b0_11_11_11_11;
    localparam logic [8:0] C_RUN   = 9'b1_10_10_10_10;
    localparam logic [8:0] C_REDIR = 9'b1_11_11_10_10;
    localparam logic [8:0] C_LDUSE = 9'b0_00_11_10_10;
    localparam logic [8:0] C_WAIT  = 9'b0_00_00_00_11;

    pipeline_hazard_ctrl #(.RESET_HOLD(2), .MEM_TIMEOUT(4)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .ex_rs1        (ex_rs1),
        .ex_rs2        (ex_rs2),
        .ex_rd         (ex_rd),
        .ex_is_load    (ex_is_load),
        .ex_redirect   (ex_redirect),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .ifid_en       (ifid_en),
        .ifid_clear    (ifid_clear),
        .idex_en       (idex_en),
        .idex_clear    (idex_clear),
        .exmem_en      (exmem_en),
        .exmem_clear   (exmem_clear),
        .memwb_en      (memwb_en),
        .memwb_clear   (memwb_clear),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt),
        .mem_timeout   (mem_timeout)
    );

    assign ctrl = {pc_en, ifid_en, ifid_clear, idex_en, idex_clear,
                   exmem_en, exmem_clear, memwb_en, memwb_clear};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
        ex_rd = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        ex_is_load = 1'b0; ex_redirect = 1'b0;
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        clear_inputs();
        #3;
        check("reset_ctrl", 32'(ctrl), 32'(C_HOLD));
        check("reset_stall", stall_cnt, 32'd0);
        check("reset_flush", flush_cnt, 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);

        // Reset hold: two held edges, RUN after the second
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("hold_0", 32'(ctrl), 32'(C_HOLD));
        tick();
        check("hold_1", 32'(ctrl), 32'(C_HOLD));
        tick();
        check("run_after_hold", 32'(ctrl), 32'(C_RUN));
        check("hold_stall", stall_cnt, 32'd0);

        // Load-use hit on rs2
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        #1;
        check("lduse_ctrl", 32'(ctrl), 32'(C_LDUSE));
        tick();
        clear_inputs();
        #1;
        check("lduse_release", 32'(ctrl), 32'(C_RUN));
        check("lduse_stall", stall_cnt, 32'd1);

        // Load to x0 never stalls
        ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        #1;
        check("lduse_x0", 32'(ctrl), 32'(C_RUN));
        tick();
        check("lduse_x0_stall", stall_cnt, 32'd1);

        // Redirect beats load-use
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; ex_redirect = 1'b1;
        #1;
        check("redir_ctrl", 32'(ctrl), 32'(C_REDIR));
        tick();
        clear_inputs();
        #1;
        check("redir_flush", flush_cnt, 32'd1);
        check("redir_stall", stall_cnt, 32'd1);

        // Memory wait with a pending redirect that must wait its turn
        mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wait_ctrl_%0d", i), 32'(ctrl), 32'(C_WAIT));
            tick();
        end
        check("wait_stall", stall_cnt, 32'd4);
        check("wait_flush", flush_cnt, 32'd1);
        mem_ready = 1'b1;
        #1;
        check("wait_ready_ctrl", 32'(ctrl), 32'(C_REDIR));
        check("wait_no_timeout", 32'(mem_timeout), 32'd0);
        tick();
        clear_inputs();
        #1;
        check("wait_exit_flush", flush_cnt, 32'd2);
        check("wait_exit_stall", stall_cnt, 32'd4);
        check("wait_exit_ctrl", 32'(ctrl), 32'(C_RUN));

        // Forwarding priority
        ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1;
        wb_rd = 5'd7; wb_reg_write = 1'b1;
        #1;
        check("fwd_a_mem", 32'(fwd_a), 32'd2);
        check("fwd_b_rf", 32'(fwd_b), 32'd0);
        ex_rs1 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
        #1;
        check("fwd_a_x0", 32'(fwd_a), 32'd0);
        ex_rs1 = 5'd7; wb_rd = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b0;
        #1;
        check("fwd_a_wb", 32'(fwd_a), 32'd1);
        ex_rs2 = 5'd9; mem_rd = 5'd9; mem_reg_write = 1'b1;
        #1;
        check("fwd_b_mem", 32'(fwd_b), 32'd2);
        check("fwd_a_wb_2", 32'(fwd_a), 32'd1);
        clear_inputs();

        // Timeout after four wait cycles, sticky
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        check("to_ctrl", 32'(ctrl), 32'(C_WAIT));
        tick(); tick(); tick();
        check("to_not_yet", 32'(mem_timeout), 32'd0);
        tick();
        check("to_set", 32'(mem_timeout), 32'd1);
        check("to_stall", stall_cnt, 32'd8);
        tick();
        check("to_sticky", 32'(mem_timeout), 32'd1);
        check("to_still_wait", 32'(ctrl), 32'(C_WAIT));
        check("to_stall_2", stall_cnt, 32'd9);

        // Asynchronous reset mid-wait
        ex_rs1 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1;
        #1;
        resetn = 1'b0;
        #1;
        check("rst_mid_ctrl", 32'(ctrl), 32'(C_HOLD));
        check("rst_mid_timeout", 32'(mem_timeout), 32'd0);
        check("rst_mid_stall", stall_cnt, 32'd0);
        check("rst_mid_flush", flush_cnt, 32'd0);
        check("rst_mid_fwd", 32'(fwd_a), 32'd2);
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("rst2_hold", 32'(ctrl), 32'(C_HOLD));
        tick();
        check("rst2_run", 32'(ctrl), 32'(C_RUN));
        check("rst2_stall", stall_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Control-side counterpart to the pipeline stage registers. It generates the `en`/`clear` controls consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB clear/enable registers, the PC enable and the EX forwarding selects. It sequences a post-reset hold, load-use stalls, branch/jump flushes and variable-latency data-memory waits, and keeps stall/flush performance counters.

## Interface
- `RESET_HOLD`, default 2: cycles the pipeline is held flushed after `resetn` rises (≥1).
- `MEM_TIMEOUT`, default 255: MEM_WAIT cycles before `mem_timeout` is raised.
- `clk`  in  1  single clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `ex_rs1`, `ex_rs2`  in  5 each  source registers of the instruction in EX.
- `ex_rd`  in  5  destination register in EX.
- `ex_is_load`  in  1  EX instruction is a load.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `mem_rd`, `mem_reg_write`  in  5/1  MEM-stage destination and write flag.
- `wb_rd`, `wb_reg_write`  in  5/1  WB-stage destination and write flag.
- `mem_req`  in  1  load or store occupying MEM.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `pc_en`  out  1  PC register enable.
- `ifid_en`, `ifid_clear`, `idex_en`, `idex_clear`, `exmem_en`, `exmem_clear`, `memwb_en`, `memwb_clear`  out  1 each  stage-register controls; clear has priority over en.
- `fwd_a`, `fwd_b`  out  2 each  EX operand source (`fwd_sel_t`).
- `stall_cnt`, `flush_cnt`  out  32 each  performance counters.
- `mem_timeout`  out  1  sticky memory timeout flag.

## Operation
- **States:** `HOLD`, `RUN`, `MEM_WAIT`.
- **`HOLD`** (entered on reset):
  - `pc_en`=0; all `*_en`=1; all `*_clear`=1.
  - A hold counter counts to `RESET_HOLD`-1, then the block moves to `RUN`.
- **`MEM_WAIT`** (highest priority):
  - Entered in `RUN` when `mem_req`=1 and `mem_ready`=0. The same condition holds the block in `MEM_WAIT`.
  - `pc_en`, `ifid_en`, `idex_en`, `exmem_en` are all 0. `memwb_clear`=1, which inserts a bubble into WB.
  - `mem_ready`=1 returns the block to `RUN` in the same cycle: the outputs that cycle are `RUN` outputs.
- **Redirect** (in `RUN`, no memory wait):
  - `ex_redirect`=1 gives `ifid_clear`=1 and `idex_clear`=1, with `pc_en`=1.
  - `flush_cnt` is incremented.
- **Load-use** (in `RUN`, no wait, no redirect):
  - Condition: `ex_is_load` && `ex_rd`≠0 && (`ex_rd`==`id_rs1` || `ex_rd`==`id_rs2`).
  - Response: `pc_en`=0, `ifid_en`=0, `idex_clear`=1.
- **Priority:** wait > redirect > load-use. A redirect arriving during `MEM_WAIT` is held implicitly, because EX is frozen. It is acted on in the first `RUN` cycle.
- **Default `RUN` outputs:** all `en`=1, all `clear`=0.
- **Forwarding** (combinational, every state):
  - Select `FWD_MEM` if `mem_reg_write` && `mem_rd`≠0 && `mem_rd`==`ex_rsX`.
  - Otherwise select `FWD_WB` under the same test on WB.
  - Otherwise select `FWD_RF`. MEM has priority over WB.
- **`stall_cnt`:** +1 on every cycle where `pc_en`=0 and state≠`HOLD`. Wraps modulo 2^32.
- **`flush_cnt`:** wraps modulo 2^32.
- **`mem_timeout`:**
  - The wait counter is cleared on entry to `MEM_WAIT` and counts cycles spent there, saturating at `MEM_TIMEOUT`.
  - On reaching `MEM_TIMEOUT`, `mem_timeout` is set and stays set until reset.
  - The state stays `MEM_WAIT`.

## Timing
- **Reset values:** state=`HOLD`, `pc_en`=0, all `en`=1, all `clear`=1, `stall_cnt`=0, `flush_cnt`=0, `mem_timeout`=0.
  - `fwd_a`/`fwd_b` follow their inputs combinationally.
  - The outputs take the reset values immediately on `resetn` falling. This holds mid-stall and mid-wait as well.
- **Output timing:** stage controls are combinational from state plus current inputs. They take effect at the next rising edge of the stage registers.
- **Hold length:** the first `RUN` cycle is the `RESET_HOLD`-th rising edge after `resetn` rises.
- **Load-use:** exactly one stall cycle per hazard. The following cycle the load is in MEM and the hazard condition is false.
- **Counters:** update on the same edge as the event they count.

## Structure
- `hazard_pkg` contains:
  - `typedef enum logic [1:0] fwd_sel_t {FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}`.
  - `typedef enum logic [1:0] hz_state_t {HOLD, RUN, MEM_WAIT}`.
  - `REG_ZERO` = 5'd0.
- Sub-module `fwd_sel_unit`: one operand's forwarding compare, instantiated twice (A and B).
- All counters and the state register live in `pipeline_hazard_ctrl`.

## Test plan
- **Reset hold:** release `resetn` with `RESET_HOLD`=2 -> `pc_en`=0 and all `clear`=1 for 2 edges; `RUN` defaults on the 3rd; `stall_cnt`=0.
- **Load-use:** `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5 -> one cycle of `pc_en`=0, `ifid_en`=0, `idex_clear`=1; `stall_cnt`=1.
  - Repeat with `ex_rd`=0 -> no stall.
- **Redirect beats load-use:** `ex_redirect`=1 together with a load-use hit -> `ifid_clear`=1, `idex_clear`=1, `pc_en`=1; `flush_cnt`=1, `stall_cnt` unchanged.
- **Memory wait:** `mem_req`=1 with `mem_ready` low for 3 cycles -> front stages frozen and `memwb_clear`=1 for 3 cycles; `stall_cnt`+=3.
  - `mem_ready`=1 -> `RUN` outputs in that cycle.
- **Forwarding priority:** `ex_rs1`=7; MEM and WB both write x7 -> `fwd_a`=`FWD_MEM`. MEM writes x0 -> `fwd_a`=`FWD_RF`. Only WB writes x7 -> `FWD_WB`.
- **Timeout and reset mid-wait:** `MEM_TIMEOUT`=4, `mem_ready` held low -> `mem_timeout`=1 after 4 wait cycles and stays set.
  - Assert `resetn`=0 mid-wait -> state `HOLD`, `mem_timeout`=0, counters 0.
